mandelbrot_pixel_sched: RTL and testbench

- Upstream frame scheduler for one Mandelbrot iteration core.
- Walks a rectangular pixel grid in raster order and computes each pixel's fixed-point c = (x0, y0) incrementally.
- Issues one start per pixel to the core, waits for its done, then presents the iteration count plus pixel coordinates on a ready/valid output stream for the colour/framebuffer stage.

---
 rtl/mandelbrot_pkg.sv | 23 ++
 rtl/mandelbrot_coord_acc.sv | 87 ++++++++
 rtl/mandelbrot_pixel_sched.sv | 194 +++++++++++++++++++
 tb/tb_mandelbrot_pixel_sched.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mandelbrot_pkg.sv
// rtl/mandelbrot_pkg.sv - shared fixed-point types, defaults and scheduler states
//
// Purpose : common definitions for the Mandelbrot pixel scheduler slice.
// Contents: default widths, fixed-point typedef fxp_t, FXP_ONE, sched_state_e.
package mandelbrot_pkg;

    localparam int INTEGER_BITS    = 8;
    localparam int FRACTIONAL_BITS = 24;
    localparam int DATA_WIDTH      = INTEGER_BITS + FRACTIONAL_BITS;
    localparam int MAX_ITER_WIDTH  = 16;

    typedef logic signed [DATA_WIDTH-1:0] fxp_t;

    localparam fxp_t FXP_ONE = fxp_t'(1) <<< FRACTIONAL_BITS;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        EMIT  = 2'd3
    } sched_state_e;

endpackage

// File: rtl/mandelbrot_coord_acc.sv
// rtl/mandelbrot_coord_acc.sv - raster col/row counters with fixed-point c accumulators
//
// Purpose : tracks the current pixel (col,row) and its c = (x_acc, y_acc).
//           load_i latches the frame geometry and resets to the top-left pixel;
//           advance_i steps one pixel in raster order (rows go downwards, so
//           y decreases by step on each new row).
// Ports   : clk_i, rst_i (async, active-high)
//           load_i, advance_i            control
//           x_start_i, y_start_i, step_i frame origin and increment (sampled on load_i)
//           width_i, height_i            frame size (sampled on load_i)
//           x_acc_o, y_acc_o             current c
//           col_o, row_o                 current pixel position
//           is_last_o                    current pixel is bottom-right
module mandelbrot_coord_acc #(
    parameter int DATA_WIDTH  = 32,
    parameter int COORD_WIDTH = 11
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   load_i,
    input  logic                   advance_i,
    input  logic [DATA_WIDTH-1:0]  x_start_i,
    input  logic [DATA_WIDTH-1:0]  y_start_i,
    input  logic [DATA_WIDTH-1:0]  step_i,
    input  logic [COORD_WIDTH-1:0] width_i,
    input  logic [COORD_WIDTH-1:0] height_i,
    output logic [DATA_WIDTH-1:0]  x_acc_o,
    output logic [DATA_WIDTH-1:0]  y_acc_o,
    output logic [COORD_WIDTH-1:0] col_o,
    output logic [COORD_WIDTH-1:0] row_o,
    output logic                   is_last_o
);
    import mandelbrot_pkg::*;

    localparam logic [COORD_WIDTH-1:0] C_ONE = COORD_WIDTH'(1);

    logic [DATA_WIDTH-1:0]  r_x_start;
    logic [DATA_WIDTH-1:0]  r_step;
    logic [COORD_WIDTH-1:0] r_width;
    logic [COORD_WIDTH-1:0] r_height;
    logic [DATA_WIDTH-1:0]  r_x_acc;
    logic [DATA_WIDTH-1:0]  r_y_acc;
    logic [COORD_WIDTH-1:0] r_col;
    logic [COORD_WIDTH-1:0] r_row;
    logic                   w_row_end;

    assign w_row_end = (r_col == r_width - C_ONE);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_x_start <= '0;
            r_step    <= '0;
            r_width   <= '0;
            r_height  <= '0;
            r_x_acc   <= '0;
            r_y_acc   <= '0;
            r_col     <= '0;
            r_row     <= '0;
        end else if (load_i) begin
            r_x_start <= x_start_i;
            r_step    <= step_i;
            r_width   <= width_i;
            r_height  <= height_i;
            r_x_acc   <= x_start_i;
            r_y_acc   <= y_start_i;
            r_col     <= '0;
            r_row     <= '0;
        end else if (advance_i) begin
            if (w_row_end) begin
                r_col   <= '0;
                r_row   <= r_row + C_ONE;
                r_x_acc <= r_x_start;
                r_y_acc <= r_y_acc - r_step;
            end else begin
                r_col   <= r_col + C_ONE;
                r_x_acc <= r_x_acc + r_step;
            end
        end
    end

    assign x_acc_o   = r_x_acc;
    assign y_acc_o   = r_y_acc;
    assign col_o     = r_col;
    assign row_o     = r_row;
    assign is_last_o = w_row_end && (r_row == r_height - C_ONE);

endmodule

// File: rtl/mandelbrot_pixel_sched.sv
// rtl/mandelbrot_pixel_sched.sv - raster pixel scheduler feeding one Mandelbrot core
//
// Purpose : walks a width x height grid, starts the core once per pixel with its
//           c = (x0, y0), waits for done, and emits iteration count + coordinates
//           on a valid/ready stream.
// Ports   : clk_i, rst_i (async, active-high)
//           frame_start_i, width_i, height_i, x_start_i, y_start_i, step_i, max_iter_i
//           core_start_o, core_x0_o, core_y0_o, core_max_iter_o, core_done_i, core_iter_i
//           pix_valid_o, pix_ready_i, pix_iter_o, pix_col_o, pix_row_o, pix_last_o
//           busy_o, frame_done_o
// Option  : MANDEL_SCHED_PERF_EN adds perf_cycles_o, the saturating count of
//           busy cycles of the current/last frame.
module mandelbrot_pixel_sched #(
    parameter int INTEGER_BITS    = mandelbrot_pkg::INTEGER_BITS,
    parameter int FRACTIONAL_BITS = mandelbrot_pkg::FRACTIONAL_BITS,
    parameter int DATA_WIDTH      = INTEGER_BITS + FRACTIONAL_BITS,
    parameter int MAX_ITER_WIDTH  = mandelbrot_pkg::MAX_ITER_WIDTH,
    parameter int COORD_WIDTH     = 11
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      frame_start_i,
    input  logic [COORD_WIDTH-1:0]    width_i,
    input  logic [COORD_WIDTH-1:0]    height_i,
    input  logic [DATA_WIDTH-1:0]     x_start_i,
    input  logic [DATA_WIDTH-1:0]     y_start_i,
    input  logic [DATA_WIDTH-1:0]     step_i,
    input  logic [MAX_ITER_WIDTH-1:0] max_iter_i,
    output logic                      core_start_o,
    output logic [DATA_WIDTH-1:0]     core_x0_o,
    output logic [DATA_WIDTH-1:0]     core_y0_o,
    output logic [MAX_ITER_WIDTH-1:0] core_max_iter_o,
    input  logic                      core_done_i,
    input  logic [MAX_ITER_WIDTH-1:0] core_iter_i,
    output logic                      pix_valid_o,
    input  logic                      pix_ready_i,
    output logic [MAX_ITER_WIDTH-1:0] pix_iter_o,
    output logic [COORD_WIDTH-1:0]    pix_col_o,
    output logic [COORD_WIDTH-1:0]    pix_row_o,
    output logic                      pix_last_o,
    output logic                      busy_o,
    output logic                      frame_done_o
`ifdef MANDEL_SCHED_PERF_EN
    ,
    output logic [31:0]               perf_cycles_o
`endif
);
    import mandelbrot_pkg::*;

    sched_state_e               r_state;
    logic                       r_busy;
    logic                       r_frame_done;
    logic                       r_core_start;
    logic [MAX_ITER_WIDTH-1:0]  r_max_iter;
    logic                       r_pix_valid;
    logic [MAX_ITER_WIDTH-1:0]  r_pix_iter;
    logic [COORD_WIDTH-1:0]     r_pix_col;
    logic [COORD_WIDTH-1:0]     r_pix_row;
    logic                       r_pix_last;

    logic                       w_accept;
    logic                       w_dims_ok;
    logic                       w_load;
    logic                       w_advance;
    logic [DATA_WIDTH-1:0]      w_x_acc;
    logic [DATA_WIDTH-1:0]      w_y_acc;
    logic [COORD_WIDTH-1:0]     w_col;
    logic [COORD_WIDTH-1:0]     w_row;
    logic                       w_is_last;

    // A new frame is only taken while idle; requests during a frame are dropped.
    assign w_accept  = frame_start_i && !r_busy && (r_state == IDLE);
    assign w_dims_ok = (width_i != '0) && (height_i != '0);
    // Empty frames never touch the accumulators, so core_x0/y0 stay put.
    assign w_load    = w_accept && w_dims_ok;
    assign w_advance = (r_state == EMIT) && pix_ready_i && !r_pix_last;

    mandelbrot_coord_acc #(
        .DATA_WIDTH  (DATA_WIDTH),
        .COORD_WIDTH (COORD_WIDTH)
    ) u_coord_acc (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .load_i    (w_load),
        .advance_i (w_advance),
        .x_start_i (x_start_i),
        .y_start_i (y_start_i),
        .step_i    (step_i),
        .width_i   (width_i),
        .height_i  (height_i),
        .x_acc_o   (w_x_acc),
        .y_acc_o   (w_y_acc),
        .col_o     (w_col),
        .row_o     (w_row),
        .is_last_o (w_is_last)
    );

    // core_start is raised on the edge that enters ISSUE, and the accumulators
    // update on that same edge, so x0/y0 are already valid for the whole start
    // cycle and only change again at the next ISSUE entry.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state      <= IDLE;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_core_start <= 1'b0;
            r_max_iter   <= '0;
            r_pix_valid  <= 1'b0;
            r_pix_iter   <= '0;
            r_pix_col    <= '0;
            r_pix_row    <= '0;
            r_pix_last   <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            r_core_start <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (r_busy) begin
                        // Empty frame: one busy cycle, then the done pulse.
                        r_busy       <= 1'b0;
                        r_frame_done <= 1'b1;
                    end else if (w_accept) begin
                        r_busy     <= 1'b1;
                        r_max_iter <= max_iter_i;
                        if (w_dims_ok) begin
                            r_state      <= ISSUE;
                            r_core_start <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    r_state <= WAIT;
                end
                WAIT: begin
                    // The core dropped done on the edge that took start, so a
                    // high level here belongs to the current pixel.
                    if (core_done_i) begin
                        r_pix_iter  <= core_iter_i;
                        r_pix_col   <= w_col;
                        r_pix_row   <= w_row;
                        r_pix_last  <= w_is_last;
                        r_pix_valid <= 1'b1;
                        r_state     <= EMIT;
                    end
                end
                EMIT: begin
                    if (pix_ready_i) begin
                        r_pix_valid <= 1'b0;
                        if (r_pix_last) begin
                            r_state      <= IDLE;
                            r_busy       <= 1'b0;
                            r_frame_done <= 1'b1;
                        end else begin
                            r_state      <= ISSUE;
                            r_core_start <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign core_start_o    = r_core_start;
    assign core_x0_o       = w_x_acc;
    assign core_y0_o       = w_y_acc;
    assign core_max_iter_o = r_max_iter;
    assign pix_valid_o     = r_pix_valid;
    assign pix_iter_o      = r_pix_iter;
    assign pix_col_o       = r_pix_col;
    assign pix_row_o       = r_pix_row;
    assign pix_last_o      = r_pix_last;
    assign busy_o          = r_busy;
    assign frame_done_o    = r_frame_done;

`ifdef MANDEL_SCHED_PERF_EN
    logic [31:0] r_perf_cycles;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_perf_cycles <= '0;
        end else if (w_accept) begin
            r_perf_cycles <= '0;
        end else if (r_busy && (r_perf_cycles != '1)) begin
            r_perf_cycles <= r_perf_cycles + 32'd1;
        end
    end

    assign perf_cycles_o = r_perf_cycles;
`endif

endmodule

// File: tb/tb_mandelbrot_pixel_sched.sv
// tb/tb_mandelbrot_pixel_sched.sv - scoreboard bench for mandelbrot_pixel_sched
module tb_mandelbrot_pixel_sched;

    logic        clk;
    logic        rst_i;
    logic        frame_start_i;
    logic [10:0] width_i, height_i;
    logic [31:0] x_start_i, y_start_i, step_i;
    logic [15:0] max_iter_i;
    logic        core_start_o;
    logic [31:0] core_x0_o, core_y0_o;
    logic [15:0] core_max_iter_o;
    logic        core_done_i;
    logic [15:0] core_iter_i;
    logic        pix_valid_o, pix_ready_i;
    logic [15:0] pix_iter_o;
    logic [10:0] pix_col_o, pix_row_o;
    logic        pix_last_o, busy_o, frame_done_o;
`ifdef MANDEL_SCHED_PERF_EN
    logic [31:0] perf_cycles_o;
`endif

    mandelbrot_pixel_sched dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .frame_start_i   (frame_start_i),
        .width_i         (width_i),
        .height_i        (height_i),
        .x_start_i       (x_start_i),
        .y_start_i       (y_start_i),
        .step_i          (step_i),
        .max_iter_i      (max_iter_i),
        .core_start_o    (core_start_o),
        .core_x0_o       (core_x0_o),
        .core_y0_o       (core_y0_o),
        .core_max_iter_o (core_max_iter_o),
        .core_done_i     (core_done_i),
        .core_iter_i     (core_iter_i),
        .pix_valid_o     (pix_valid_o),
        .pix_ready_i     (pix_ready_i),
        .pix_iter_o      (pix_iter_o),
        .pix_col_o       (pix_col_o),
        .pix_row_o       (pix_row_o),
        .pix_last_o      (pix_last_o),
        .busy_o          (busy_o),
        .frame_done_o    (frame_done_o)
`ifdef MANDEL_SCHED_PERF_EN
        ,
        .perf_cycles_o   (perf_cycles_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { logic [31:0] x; logic [31:0] y; logic [15:0] m; } start_t;
    typedef struct { logic [15:0] iter; logic [10:0] col; logic [10:0] row; logic last; } pix_t;

    start_t exp_start[$];
    pix_t   exp_pix[$];
    int     exp_done[$];   // 1 = frame with pixels, 0 = empty frame

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Arbitrary but deterministic stand-in for the escape-time result.
    function automatic logic [15:0] ref_iter(input logic [31:0] x, input logic [31:0] y, input logic [15:0] m);
        ref_iter = x[15:0] ^ y[31:16] ^ m ^ 16'h5a5a;
    endfunction

    // Behavioural core: done level drops on the start edge, rises after lat edges.
    int          lat_fixed = -1;
    logic        core_busy;
    int          core_cnt;
    logic [31:0] cx, cy;
    logic [15:0] cm;
    always @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            core_done_i <= 1'b0;
            core_iter_i <= '0;
            core_busy   <= 1'b0;
            core_cnt    <= 0;
        end else if (core_start_o) begin
            core_done_i <= 1'b0;
            core_busy   <= 1'b1;
            core_cnt    <= (lat_fixed >= 0) ? lat_fixed : int'($urandom_range(0, 4));
            cx          <= core_x0_o;
            cy          <= core_y0_o;
            cm          <= core_max_iter_o;
        end else if (core_busy) begin
            if (core_cnt == 0) begin
                core_done_i <= 1'b1;
                core_iter_i <= ref_iter(cx, cy, cm);
                core_busy   <= 1'b0;
            end else begin
                core_cnt <= core_cnt - 1;
            end
        end
    end

    // Output ready driver.
    logic rdy_rand  = 1'b0;
    logic rdy_force = 1'b1;
    initial begin
        pix_ready_i = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            pix_ready_i = rdy_rand ? ($urandom_range(0, 2) != 0) : rdy_force;
        end
    end

    // Monitor / scoreboard.
    logic        prev_stall, prev_last_hs, prev_busy;
    logic [15:0] prev_iter;
    logic [10:0] prev_col, prev_row;
    logic        prev_last;
    initial begin
        prev_stall = 0; prev_last_hs = 0; prev_busy = 0;
        prev_iter = 0; prev_col = 0; prev_row = 0; prev_last = 0;
        forever begin
            @(negedge clk);
            if (rst_i) begin
                prev_stall = 0; prev_last_hs = 0; prev_busy = 0;
            end else begin
                if (core_start_o) begin
                    check("start_expected", exp_start.size() != 0, 1);
                    check("start_while_valid", pix_valid_o, 0);
                    if (exp_start.size() != 0) begin
                        start_t s;
                        s = exp_start.pop_front();
                        check("core_x0", core_x0_o, s.x);
                        check("core_y0", core_y0_o, s.y);
                        check("core_max_iter", core_max_iter_o, s.m);
                    end
                end
                if (prev_stall) begin
                    check("hold_valid", pix_valid_o, 1);
                    check("hold_iter", pix_iter_o, prev_iter);
                    check("hold_col", pix_col_o, prev_col);
                    check("hold_row", pix_row_o, prev_row);
                    check("hold_last", pix_last_o, prev_last);
                end
                if (pix_valid_o && pix_ready_i) begin
                    check("pix_expected", exp_pix.size() != 0, 1);
                    if (exp_pix.size() != 0) begin
                        pix_t p;
                        p = exp_pix.pop_front();
                        check("pix_iter", pix_iter_o, p.iter);
                        check("pix_col", pix_col_o, p.col);
                        check("pix_row", pix_row_o, p.row);
                        check("pix_last", pix_last_o, p.last);
                    end
                end
                if (frame_done_o) begin
                    check("done_expected", exp_done.size() != 0, 1);
                    check("done_busy_low", busy_o, 0);
                    check("done_prev_busy", prev_busy, 1);
                    if (exp_done.size() != 0) begin
                        int code;
                        code = exp_done.pop_front();
                        if (code == 1) check("done_after_last_hs", prev_last_hs, 1);
                    end
                end
                prev_stall   = pix_valid_o && !pix_ready_i;
                prev_last_hs = pix_valid_o && pix_ready_i && pix_last_o;
                prev_busy    = busy_o;
                prev_iter    = pix_iter_o;
                prev_col     = pix_col_o;
                prev_row     = pix_row_o;
                prev_last    = pix_last_o;
            end
        end
    end

    task automatic start_frame(input int w, input int h, input logic [31:0] xs,
                               input logic [31:0] ys, input logic [31:0] st, input logic [15:0] mi);
        @(posedge clk);
        #1;
        width_i = 11'(w); height_i = 11'(h);
        x_start_i = xs; y_start_i = ys; step_i = st; max_iter_i = mi;
        frame_start_i = 1'b1;
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                start_t s;
                pix_t   p;
                s.x = xs + st * 32'(c);
                s.y = ys - st * 32'(r);
                s.m = mi;
                p.iter = ref_iter(s.x, s.y, mi);
                p.col  = 11'(c);
                p.row  = 11'(r);
                p.last = (c == w - 1) && (r == h - 1);
                exp_start.push_back(s);
                exp_pix.push_back(p);
            end
        end
        exp_done.push_back((w == 0 || h == 0) ? 0 : 1);
        @(posedge clk);
        #1;
        frame_start_i = 1'b0;
        // Config must only matter on the accepted start.
        width_i = 11'($urandom); height_i = 11'($urandom);
        x_start_i = $urandom; y_start_i = $urandom; step_i = $urandom; max_iter_i = 16'($urandom);
    endtask

    task automatic wait_idle(output int cyc);
        int k;
        cyc = 0;
        k = 0;
        @(negedge clk);
        while (busy_o === 1'b1 && k < 4000) begin
            cyc++;
            k++;
            @(negedge clk);
        end
        check("frame_timeout", busy_o, 0);
        @(posedge clk);
        check("start_q_empty", exp_start.size(), 0);
        check("pix_q_empty", exp_pix.size(), 0);
        check("done_q_empty", exp_done.size(), 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_core_start"}, core_start_o, 0);
        check({tag, "_core_x0"}, core_x0_o, 0);
        check({tag, "_core_y0"}, core_y0_o, 0);
        check({tag, "_core_max_iter"}, core_max_iter_o, 0);
        check({tag, "_pix_valid"}, pix_valid_o, 0);
        check({tag, "_pix_iter"}, pix_iter_o, 0);
        check({tag, "_pix_col"}, pix_col_o, 0);
        check({tag, "_pix_row"}, pix_row_o, 0);
        check({tag, "_pix_last"}, pix_last_o, 0);
        check({tag, "_busy"}, busy_o, 0);
        check({tag, "_frame_done"}, frame_done_o, 0);
    endtask

    initial begin
        int cyc;
        int k;
        rst_i = 1'b1;
        frame_start_i = 1'b0;
        width_i = '0; height_i = '0;
        x_start_i = '0; y_start_i = '0; step_i = '0; max_iter_i = '0;
        #1;
        check_all_zero("reset");
        repeat (3) @(posedge clk);
        #3 rst_i = 1'b0;

        // 2x2 directed frame: (-2,1) (-1.5,1) (-2,0.5) (-1.5,0.5).
        rdy_rand = 0; rdy_force = 1;
        start_frame(2, 2, 32'hFE000000, 32'h01000000, 32'h00800000, 16'd100);
        wait_idle(cyc);

        // Backpressure: hold ready low for 5 EMIT cycles.
        rdy_force = 0;
        start_frame(2, 1, 32'h00100000, 32'hFF000000, 32'h00040000, 16'd255);
        k = 0;
        @(negedge clk);
        while (!pix_valid_o && k < 200) begin k++; @(negedge clk); end
        check("bp_valid_seen", pix_valid_o, 1);
        repeat (5) begin
            @(negedge clk);
            check("bp_no_start", core_start_o, 0);
        end
        @(posedge clk);
        #1 rdy_force = 1;
        wait_idle(cyc);

        // Empty frame.
        start_frame(0, 3, 32'h12345678, 32'h0, 32'h1, 16'd7);
        wait_idle(cyc);
        check("empty_busy_cycles", cyc, 1);

        // Restart request mid-frame is ignored.
        rdy_rand = 1;
        start_frame(3, 2, 32'hFF000000, 32'h00800000, 32'h00200000, 16'd50);
        repeat (6) @(posedge clk);
        #1;
        width_i = 11'd1; height_i = 11'd1; step_i = 32'h01000000; frame_start_i = 1'b1;
        @(posedge clk);
        #1 frame_start_i = 1'b0;
        wait_idle(cyc);

        // Random frames, including wrap-around arithmetic.
        for (int f = 0; f < 6; f++) begin
            start_frame($urandom_range(1, 5), $urandom_range(1, 4), $urandom, $urandom,
                        $urandom, 16'($urandom));
            wait_idle(cyc);
        end

        // Reset while waiting on the core abandons the frame.
        rdy_rand = 0; rdy_force = 1;
        lat_fixed = 20;
        start_frame(2, 2, 32'h00000100, 32'h00000200, 32'h00000010, 16'd9);
        k = 0;
        @(negedge clk);
        while (!core_start_o && k < 50) begin k++; @(negedge clk); end
        repeat (3) @(negedge clk);
        #2 rst_i = 1'b1;
        #1;
        check_all_zero("midreset");
        exp_start.delete();
        exp_pix.delete();
        exp_done.delete();
        @(posedge clk);
        #3 rst_i = 1'b0;
        lat_fixed = -1;
        repeat (3) @(negedge clk);
        check("post_reset_no_done", frame_done_o, 0);
        start_frame(1, 1, 32'h80000000, 32'h7FFFFFFF, 32'h00000001, 16'hFFFF);
        wait_idle(cyc);

`ifdef MANDEL_SCHED_PERF_EN
        lat_fixed = 9;
        start_frame(1, 1, 32'h00400000, 32'h00400000, 32'h00100000, 16'd20);
        wait_idle(cyc);
        check("perf_vs_busy", perf_cycles_o, 32'(cyc));
        check("perf_cycles", perf_cycles_o, 32'd13);
        repeat (5) @(posedge clk);
        #1 check("perf_hold", perf_cycles_o, 32'd13);
        lat_fixed = -1;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
